// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: source selects, load types,
// FSM state encoding and the byte-offset width helper.
package wb_pkg;

    // Write-back source select; 2'b11 falls back to the ALU result.
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Load type encodings carried in funct3.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2
    } wb_state_t;

    // Width of the byte offset inside one XLEN-wide memory word.
    function automatic int off_width(input int xlen);
        return $clog2(xlen / 8);
    endfunction

endpackage

// File: rtl/load_extend.sv
// Extracts a byte, halfword or word from a memory read word at a given byte
// offset and sign- or zero-extends it to the full datapath width.
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              word,
    input  logic [2:0]                   funct3,
    input  logic [off_width(XLEN)-1:0]   offset,
    output logic [XLEN-1:0]              value
);

    localparam int OFF_W = off_width(XLEN);

    logic [OFF_W-1:0] off_half;
    logic [OFF_W-1:0] off_word;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      word_v;

    // Round the offset down to the access size and pick the addressed lanes.
    always_comb begin
        off_half = offset & ~OFF_W'(1);
        off_word = offset & ~OFF_W'(3);
        byte_v   = word[{offset, 3'b000} +: 8];
        half_v   = word[{off_half, 3'b000} +: 16];
        word_v   = word[{off_word, 3'b000} +: 32];
    end

    // Extend the selected lane according to the load type; LD and unknown
    // codes pass the whole word through.
    always_comb begin
        value = word;
        case (funct3)
            F3_LB: begin
                value      = {XLEN{byte_v[7]}};
                value[7:0] = byte_v;
            end
            F3_LBU: begin
                value      = '0;
                value[7:0] = byte_v;
            end
            F3_LH: begin
                value       = {XLEN{half_v[15]}};
                value[15:0] = half_v;
            end
            F3_LHU: begin
                value       = '0;
                value[15:0] = half_v;
            end
            F3_LW: begin
                value       = {XLEN{word_v[31]}};
                value[31:0] = word_v;
            end
            F3_LWU: begin
                value       = '0;
                value[31:0] = word_v;
            end
            F3_LD: begin
                value = word;
            end
            default: begin
                value = word;
            end
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: registers the MEM-stage bundle, waits for late load data
// with a bounded stall, supports flush, and counts retired instructions.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        flush,
    input  logic                        mem_done,
    input  logic [XLEN-1:0]             data_mem,
    input  logic [XLEN-1:0]             result_alu,
    input  logic [XLEN-1:0]             pc_plus4,
    input  logic [1:0]                  in_WbSel,
    input  logic                        in_RegWrite,
    input  logic [REG_ADDR_W-1:0]       in_RegDest,
    input  logic                        in_PCSrc,
    input  logic [2:0]                  in_funct3,
    input  logic [off_width(XLEN)-1:0]  in_addr_lo,
    output logic                        stall_req,
    output logic                        out_valid,
    output logic [XLEN-1:0]             data_wb,
    output logic                        out_RegWrite,
    output logic [REG_ADDR_W-1:0]       out_RegDest,
    output logic                        out_PCSrc,
    output logic                        err_timeout,
    output logic [CNT_W-1:0]            instret
);

    localparam int OFF_W  = off_width(XLEN);
    // The counter only needs to reach WAIT_LIMIT-1; the timeout fires there.
    localparam int WCNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);

    wb_state_t state;
    wb_state_t state_next;

    logic [1:0]            held_wbsel;
    logic                  held_regwrite;
    logic [REG_ADDR_W-1:0] held_regdest;
    logic                  held_pcsrc;
    logic [2:0]            held_funct3;
    logic [OFF_W-1:0]      held_addr_lo;
    logic [XLEN-1:0]       held_alu;
    logic [XLEN-1:0]       held_pc4;
    logic [XLEN-1:0]       held_mem;

    logic [WCNT_W-1:0]     wait_cnt;
    logic [CNT_W-1:0]      instret_q;
    logic                  err_q;

    logic                  can_capture;
    logic                  capture_is_load;
    logic                  timeout_hit;
    logic                  drop_load;
    logic                  latch_mem;
    logic [XLEN-1:0]       load_val;

    // Decode the capture and late-data conditions used by the FSM and registers.
    always_comb begin
        can_capture     = (state != ST_WAIT) && in_valid && !flush;
        capture_is_load = (in_WbSel == WB_MEM);
        timeout_hit     = (WAIT_LIMIT != 0) && (wait_cnt == WCNT_W'(WAIT_LIMIT - 1));
        latch_mem       = (can_capture && capture_is_load && mem_done)
                       || ((state == ST_WAIT) && mem_done && !flush);
    end

    // Next-state logic: flush beats both capture and a late mem_done.
    always_comb begin
        state_next = state;
        drop_load  = 1'b0;
        case (state)
            ST_IDLE, ST_COMMIT: begin
                if (can_capture) begin
                    if (capture_is_load && !mem_done) begin
                        state_next = ST_WAIT;
                    end else begin
                        state_next = ST_COMMIT;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (mem_done) begin
                    state_next = ST_COMMIT;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                    drop_load  = 1'b1;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register; reset returns to IDLE at once, even in the middle of a wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Hold the instruction bundle for the cycle(s) until it commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_wbsel    <= WB_ALU;
            held_regwrite <= 1'b0;
            held_regdest  <= '0;
            held_pcsrc    <= 1'b0;
            held_funct3   <= '0;
            held_addr_lo  <= '0;
            held_alu      <= '0;
            held_pc4      <= '0;
        end else if (can_capture) begin
            held_wbsel    <= in_WbSel;
            held_regwrite <= in_RegWrite;
            held_regdest  <= in_RegDest;
            held_pcsrc    <= in_PCSrc;
            held_funct3   <= in_funct3;
            held_addr_lo  <= in_addr_lo;
            held_alu      <= result_alu;
            held_pc4      <= pc_plus4;
        end
    end

    // Latch the raw load word when it arrives, in the capture cycle or during WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_mem <= '0;
        end else if (latch_mem) begin
            held_mem <= data_mem;
        end
    end

    // Count cycles spent in WAIT; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Retired-instruction counter, advancing once per commit cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (state == ST_COMMIT) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Timeout pulse is raised for the cycle right after the load is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= drop_load;
        end
    end

    load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .word   (held_mem),
        .funct3 (held_funct3),
        .offset (held_addr_lo),
        .value  (load_val)
    );

    // Drive the register-file side from the held bundle only while committing.
    always_comb begin
        stall_req    = (state == ST_WAIT);
        out_valid    = 1'b0;
        out_RegWrite = 1'b0;
        out_RegDest  = '0;
        out_PCSrc    = 1'b0;
        data_wb      = '0;
        err_timeout  = err_q;
        if (state == ST_COMMIT) begin
            out_valid    = 1'b1;
            out_RegWrite = held_regwrite && (held_regdest != '0);
            out_RegDest  = held_regdest;
            out_PCSrc    = held_pcsrc;
            case (held_wbsel)
                WB_ALU:  data_wb = held_alu;
                WB_MEM:  data_wb = load_val;
                WB_PC4:  data_wb = held_pc4;
                default: data_wb = held_alu;
            endcase
        end
    end

    // The visible count already includes the instruction committing this cycle.
    assign instret = instret_q + CNT_W'(state == ST_COMMIT);

endmodule

// File: tb/tb_writeback_unit.sv
// Directed testbench for writeback_unit with a transaction-level reference model.
module tb_writeback_unit;

    localparam int WAIT_LIMIT = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        flush;
    logic        mem_done;
    logic [31:0] data_mem;
    logic [31:0] result_alu;
    logic [31:0] pc_plus4;
    logic [1:0]  in_WbSel;
    logic        in_RegWrite;
    logic [4:0]  in_RegDest;
    logic        in_PCSrc;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;

    logic        stall_req,    stall_req_s;
    logic        out_valid,    out_valid_s;
    logic [31:0] data_wb,      data_wb_s;
    logic        out_RegWrite, out_RegWrite_s;
    logic [4:0]  out_RegDest,  out_RegDest_s;
    logic        out_PCSrc,    out_PCSrc_s;
    logic        err_timeout,  err_timeout_s;
    logic [63:0] instret;
    logic [2:0]  instret_s;

    int checks = 0;
    int errors = 0;

    writeback_unit #(.XLEN(32), .REG_ADDR_W(5), .WAIT_LIMIT(WAIT_LIMIT), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .mem_done(mem_done),
        .data_mem(data_mem), .result_alu(result_alu), .pc_plus4(pc_plus4),
        .in_WbSel(in_WbSel), .in_RegWrite(in_RegWrite), .in_RegDest(in_RegDest),
        .in_PCSrc(in_PCSrc), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .stall_req(stall_req), .out_valid(out_valid), .data_wb(data_wb),
        .out_RegWrite(out_RegWrite), .out_RegDest(out_RegDest), .out_PCSrc(out_PCSrc),
        .err_timeout(err_timeout), .instret(instret)
    );

    // Narrow-counter copy so the wrap of instret is reached in a short run.
    writeback_unit #(.XLEN(32), .REG_ADDR_W(5), .WAIT_LIMIT(WAIT_LIMIT), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .mem_done(mem_done),
        .data_mem(data_mem), .result_alu(result_alu), .pc_plus4(pc_plus4),
        .in_WbSel(in_WbSel), .in_RegWrite(in_RegWrite), .in_RegDest(in_RegDest),
        .in_PCSrc(in_PCSrc), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .stall_req(stall_req_s), .out_valid(out_valid_s), .data_wb(data_wb_s),
        .out_RegWrite(out_RegWrite_s), .out_RegDest(out_RegDest_s), .out_PCSrc(out_PCSrc_s),
        .err_timeout(err_timeout_s), .instret(instret_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: one pending instruction, whether it is waiting for data,
    // how long it has waited, and whether it is visible as a commit this cycle.
    logic        m_commit, m_wait, m_err;
    int          m_waited;
    logic [63:0] m_count;
    logic [1:0]  p_sel;
    logic        p_rw, p_pcsrc;
    logic [4:0]  p_rd;
    logic [2:0]  p_f3;
    logic [1:0]  p_off;
    logic [31:0] p_alu, p_pc4, p_word;

    function automatic logic [31:0] loadValue(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] off);
        logic [31:0] v;
        int unsigned shift;
        case (f3[1:0])
            2'b00: begin
                shift = 8 * off;
                v = (w >> shift) & 32'h0000_00FF;
                if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                shift = 8 * (off & 2'b10);
                v = (w >> shift) & 32'h0000_FFFF;
                if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] expectedData();
        if (!m_commit) return 32'h0;
        if (p_sel == 2'b01) return loadValue(p_word, p_f3, p_off);
        if (p_sel == 2'b10) return p_pc4;
        return p_alu;
    endfunction

    initial begin
        logic commit_next;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_commit = 1'b0; m_wait = 1'b0; m_err = 1'b0; m_waited = 0; m_count = '0;
            end else begin
                if (m_commit) m_count = m_count + 64'd1;
                commit_next = 1'b0;
                m_err = 1'b0;
                if (m_wait) begin
                    m_waited = m_waited + 1;
                    if (flush) begin
                        m_wait = 1'b0;
                    end else if (mem_done) begin
                        p_word = data_mem;
                        m_wait = 1'b0;
                        commit_next = 1'b1;
                    end else if (WAIT_LIMIT != 0 && m_waited == WAIT_LIMIT) begin
                        m_wait = 1'b0;
                        m_err = 1'b1;
                    end
                end else if (in_valid && !flush) begin
                    p_sel = in_WbSel; p_rw = in_RegWrite; p_rd = in_RegDest; p_pcsrc = in_PCSrc;
                    p_f3 = in_funct3; p_off = in_addr_lo; p_alu = result_alu; p_pc4 = pc_plus4;
                    if (in_WbSel == 2'b01 && !mem_done) begin
                        m_wait = 1'b1;
                        m_waited = 0;
                    end else begin
                        commit_next = 1'b1;
                        if (in_WbSel == 2'b01) p_word = data_mem;
                    end
                end
                m_commit = commit_next;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare both DUT copies against the model on every cycle out of reset.
    initial begin
        logic [31:0] ed;
        logic [63:0] ei;
        logic        erw;
        forever begin
            @(negedge clk);
            if (!rst) begin
                ed  = expectedData();
                ei  = m_count + 64'(m_commit);
                erw = m_commit && p_rw && (p_rd != 5'd0);
                checkOutput("cyc.out_valid",    64'(out_valid),      64'(m_commit));
                checkOutput("cyc.stall_req",    64'(stall_req),      64'(m_wait));
                checkOutput("cyc.err_timeout",  64'(err_timeout),    64'(m_err));
                checkOutput("cyc.data_wb",      64'(data_wb),        64'(ed));
                checkOutput("cyc.out_RegWrite", 64'(out_RegWrite),   64'(erw));
                checkOutput("cyc.instret",      instret,             ei);
                checkOutput("cyc.s.out_valid",  64'(out_valid_s),    64'(m_commit));
                checkOutput("cyc.s.stall_req",  64'(stall_req_s),    64'(m_wait));
                checkOutput("cyc.s.err",        64'(err_timeout_s),  64'(m_err));
                checkOutput("cyc.s.data_wb",    64'(data_wb_s),      64'(ed));
                checkOutput("cyc.s.RegWrite",   64'(out_RegWrite_s), 64'(erw));
                checkOutput("cyc.s.instret",    64'(instret_s),      64'(ei[2:0]));
                if (!m_wait) begin
                    checkOutput("cyc.out_RegDest",   64'(out_RegDest),   m_commit ? 64'(p_rd) : 64'd0);
                    checkOutput("cyc.out_PCSrc",     64'(out_PCSrc),     m_commit ? 64'(p_pcsrc) : 64'd0);
                    checkOutput("cyc.s.out_RegDest", 64'(out_RegDest_s), m_commit ? 64'(p_rd) : 64'd0);
                    checkOutput("cyc.s.out_PCSrc",   64'(out_PCSrc_s),   m_commit ? 64'(p_pcsrc) : 64'd0);
                end
            end
        end
    end

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic setIdle();
        in_valid = 1'b0; flush = 1'b0; mem_done = 1'b0;
    endtask

    task automatic setAlu(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] val,
                          input logic pcsrc);
        in_valid = 1'b1; flush = 1'b0; mem_done = 1'b0;
        in_WbSel = sel; in_RegWrite = 1'b1; in_RegDest = rd; in_PCSrc = pcsrc;
        result_alu = val; pc_plus4 = 32'h0000_0FF0; in_funct3 = 3'b000; in_addr_lo = 2'd0;
    endtask

    task automatic setLoad(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w,
                           input logic done, input logic [4:0] rd);
        in_valid = 1'b1; flush = 1'b0; mem_done = done;
        in_WbSel = 2'b01; in_RegWrite = 1'b1; in_RegDest = rd; in_PCSrc = 1'b0;
        in_funct3 = f3; in_addr_lo = off; data_mem = w; result_alu = 32'hBAD0_BAD0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] word;
        logic [31:0] want;
    } ld_vec_t;

    ld_vec_t ld_tab[8] = '{
        '{3'b001, 2'd2, 32'h8000_1234, 32'hFFFF_8000},
        '{3'b001, 2'd3, 32'h8000_1234, 32'hFFFF_8000},
        '{3'b101, 2'd0, 32'hABCD_8765, 32'h0000_8765},
        '{3'b000, 2'd3, 32'h7F00_0000, 32'h0000_007F},
        '{3'b100, 2'd1, 32'h0000_FF00, 32'h0000_00FF},
        '{3'b010, 2'd3, 32'hCAFE_BABE, 32'hCAFE_BABE},
        '{3'b110, 2'd0, 32'h8765_4321, 32'h8765_4321},
        '{3'b111, 2'd1, 32'h1357_9BDF, 32'h1357_9BDF}
    };

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; flush = 1'b0; mem_done = 1'b0; data_mem = '0; result_alu = '0;
        pc_plus4 = '0; in_WbSel = '0; in_RegWrite = 1'b0; in_RegDest = '0; in_PCSrc = 1'b0;
        in_funct3 = '0; in_addr_lo = '0;
        applyStimulus(2);
        rst = 1'b0;
        checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset.data_wb",   64'(data_wb),   64'd0);
        checkOutput("reset.instret",   instret,        64'd0);
        checkOutput("reset.stall_req", 64'(stall_req), 64'd0);

        // Plain ALU op, committed one cycle after capture.
        setAlu(2'b00, 5'd5, 32'h0000_1234, 1'b1);
        applyStimulus(1);
        checkOutput("alu.out_valid",   64'(out_valid),    64'd1);
        checkOutput("alu.RegWrite",    64'(out_RegWrite), 64'd1);
        checkOutput("alu.RegDest",     64'(out_RegDest),  64'd5);
        checkOutput("alu.data_wb",     64'(data_wb),      64'h1234);
        checkOutput("alu.instret",     instret,           64'd1);
        setIdle();
        applyStimulus(1);

        // LB answered three cycles late, then LBU on the same word.
        setLoad(3'b000, 2'd2, 32'h0000_0000, 1'b0, 5'd6);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("late.stall_req", 64'(stall_req), 64'd1);
        end
        mem_done = 1'b1; data_mem = 32'h0080_0000;
        applyStimulus(1);
        checkOutput("late.lb.stall",   64'(stall_req), 64'd0);
        checkOutput("late.lb.data_wb", 64'(data_wb),   64'hFFFF_FF80);
        setLoad(3'b100, 2'd2, 32'h0080_0000, 1'b1, 5'd7);
        applyStimulus(1);
        checkOutput("late.lbu.data_wb", 64'(data_wb), 64'h0000_0080);
        setIdle();
        applyStimulus(1);

        // Load never answered: dropped after WAIT_LIMIT wait cycles.
        setLoad(3'b010, 2'd0, 32'h0, 1'b0, 5'd9);
        applyStimulus(1);
        setIdle();
        applyStimulus(WAIT_LIMIT - 1);
        checkOutput("tmo.last_wait.err", 64'(err_timeout), 64'd0);
        applyStimulus(1);
        checkOutput("tmo.err_timeout", 64'(err_timeout), 64'd1);
        checkOutput("tmo.out_valid",   64'(out_valid),   64'd0);
        checkOutput("tmo.stall_req",   64'(stall_req),   64'd0);
        checkOutput("tmo.instret",     instret,          64'd3);
        applyStimulus(1);
        checkOutput("tmo.err_cleared", 64'(err_timeout), 64'd0);

        // Link writes: x0 suppresses the write enable, x1 does not.
        setAlu(2'b10, 5'd0, 32'h0000_DEAD, 1'b0);
        pc_plus4 = 32'h0000_0104;
        applyStimulus(1);
        checkOutput("jal.x0.valid",    64'(out_valid),    64'd1);
        checkOutput("jal.x0.RegWrite", 64'(out_RegWrite), 64'd0);
        in_RegDest = 5'd1;
        applyStimulus(1);
        checkOutput("jal.x1.RegWrite", 64'(out_RegWrite), 64'd1);
        checkOutput("jal.x1.data_wb",  64'(data_wb),      64'h0104);
        setIdle();
        applyStimulus(1);

        // Flush in WAIT wins over a same-cycle mem_done; a later mem_done is ignored.
        setLoad(3'b010, 2'd0, 32'h0, 1'b0, 5'd10);
        applyStimulus(1);
        setIdle();
        flush = 1'b1; mem_done = 1'b1; data_mem = 32'h5555_5555;
        applyStimulus(1);
        checkOutput("flush.wait.stall", 64'(stall_req), 64'd0);
        checkOutput("flush.wait.valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        applyStimulus(1);
        checkOutput("flush.late_done.valid", 64'(out_valid), 64'd0);
        setIdle();
        applyStimulus(1);

        // Flush during a commit keeps that commit but cancels the new capture.
        setAlu(2'b00, 5'd7, 32'h0000_0077, 1'b0);
        applyStimulus(1);
        setAlu(2'b00, 5'd8, 32'h0000_0088, 1'b0);
        flush = 1'b1;
        checkOutput("flush.commit.valid", 64'(out_valid), 64'd1);
        checkOutput("flush.commit.data",  64'(data_wb),   64'h77);
        applyStimulus(1);
        checkOutput("flush.commit.after", 64'(out_valid), 64'd0);
        checkOutput("flush.commit.cnt",   instret,        64'd6);
        setIdle();
        applyStimulus(1);

        // Four back-to-back ALU ops; the narrow counter wraps on the eighth commit.
        for (int i = 0; i < 4; i++) begin
            setAlu((i == 2) ? 2'b11 : 2'b00, 5'(i + 1), 32'(17 * (i + 1)), 1'(i));
            applyStimulus(1);
            checkOutput("b2b.valid", 64'(out_valid), 64'd1);
            checkOutput("b2b.data",  64'(data_wb),   64'(17 * (i + 1)));
            if (i == 1) checkOutput("b2b.wrap", 64'(instret_s), 64'd0);
        end
        setIdle();
        applyStimulus(1);

        // Extraction table with data present in the capture cycle.
        for (int i = 0; i < 8; i++) begin
            setLoad(ld_tab[i].f3, ld_tab[i].off, ld_tab[i].word, 1'b1, 5'd12);
            applyStimulus(1);
            checkOutput("ext.data_wb", 64'(data_wb), 64'(ld_tab[i].want));
        end
        setIdle();
        applyStimulus(1);

        // Asynchronous reset in the middle of a wait.
        setLoad(3'b010, 2'd0, 32'h0, 1'b0, 5'd13);
        applyStimulus(1);
        setIdle();
        applyStimulus(1);
        #1 rst = 1'b1;
        #1;
        checkOutput("rstwait.stall", 64'(stall_req),   64'd0);
        checkOutput("rstwait.err",   64'(err_timeout), 64'd0);
        checkOutput("rstwait.cnt",   instret,          64'd0);
        applyStimulus(1);
        rst = 1'b0;
        applyStimulus(2);
        checkOutput("rstwait.after.err", 64'(err_timeout), 64'd0);

        applyStimulus(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
